// File: rtl/can_frame_tracker.sv
// Receive-side CAN frame sequencer, clocked on the bit sample point. It handles bus integration,
// SOF detection, destuffing and field capture up to the EOF and intermission window.
module can_frame_tracker #(
    parameter int IDLE_BITS = 11,
    parameter int EOF_BITS  = 7,
    parameter int IFS_BITS  = 3
) (
    input  logic        SP,
    input  logic        reset,
    input  logic        RX,
    output logic        EOF_Flag,
    output logic [28:0] ID,
    output logic        IDE,
    output logic        RTR,
    output logic [3:0]  DLC,
    output logic [63:0] Data,
    output logic [14:0] CRC_Rx,
    output logic        Frame_Done,
    output logic        Stuff_Error,
    output logic        Form_Error
);
    typedef enum logic [4:0] {
        ST_INTEGRATE, ST_IDLE, ST_IDA, ST_SRR, ST_IDE, ST_IDB, ST_RTR, ST_R1, ST_R0,
        ST_DLC, ST_DATA, ST_CRC, ST_CRC_DEL, ST_ACK_SLOT, ST_ACK_DEL, ST_EOF, ST_IFS,
        ST_ERR_WAIT
    } state_t;

    localparam logic [4:0] IDLE_LAST = 5'(IDLE_BITS - 1);
    localparam logic [4:0] EOF_LAST  = 5'(EOF_BITS - 1);
    localparam logic [4:0] IFS_LAST  = 5'(IFS_BITS - 1);

    state_t      state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [2:0]  run_r, run_s;
    logic        last_r, last_s;
    logic [6:0]  data_left_r, data_left_s;
    logic [28:0] id_r, id_s;
    logic        ide_r, ide_s;
    logic        rtr_r, rtr_s;
    logic [3:0]  dlc_r, dlc_s;
    logic [63:0] data_r, data_s;
    logic [14:0] crc_r, crc_s;
    logic        eof_flag_r, eof_flag_s;
    logic        frame_done_r, frame_done_s;
    logic        stuff_err_r, stuff_err_s;
    logic        form_err_r, form_err_s;
    logic        in_stuff_s;
    logic        deliver_s;
    logic        sof_s;

    assign EOF_Flag    = eof_flag_r;
    assign ID          = id_r;
    assign IDE         = ide_r;
    assign RTR         = rtr_r;
    assign DLC         = dlc_r;
    assign Data        = data_r;
    assign CRC_Rx      = crc_r;
    assign Frame_Done  = frame_done_r;
    assign Stuff_Error = stuff_err_r;
    assign Form_Error  = form_err_r;

    // Next-state, destuffing and field capture for one sampled bit
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        run_s        = run_r;
        last_s       = last_r;
        data_left_s  = data_left_r;
        id_s         = id_r;
        ide_s        = ide_r;
        rtr_s        = rtr_r;
        dlc_s        = dlc_r;
        data_s       = data_r;
        crc_s        = crc_r;
        eof_flag_s   = eof_flag_r;
        frame_done_s = 1'b0;
        stuff_err_s  = stuff_err_r;
        form_err_s   = form_err_r;
        deliver_s    = 1'b1;
        sof_s        = 1'b0;

        // A stuff bit can still be pending right after the last CRC bit
        in_stuff_s = (state_r inside {ST_IDA, ST_SRR, ST_IDE, ST_IDB, ST_RTR, ST_R1, ST_R0,
                                      ST_DLC, ST_DATA, ST_CRC})
                     || ((state_r == ST_CRC_DEL) && (run_r == 3'd5));

        if (in_stuff_s) begin
            if (run_r == 3'd5) begin
                deliver_s = 1'b0;
                if (RX != last_r) begin
                    run_s  = 3'd1;
                    last_s = RX;
                end else begin
                    stuff_err_s = 1'b0;
                    eof_flag_s  = 1'b1;
                    cnt_s       = 5'd0;
                    state_s     = ST_ERR_WAIT;
                end
            end else if (RX == last_r) begin
                run_s = (run_r == 3'd7) ? 3'd7 : run_r + 3'd1;
            end else begin
                run_s  = 3'd1;
                last_s = RX;
            end
        end else begin
            run_s = run_r;
        end

        if (deliver_s) begin
            case (state_r)
                ST_INTEGRATE, ST_ERR_WAIT: begin
                    eof_flag_s = 1'b1;
                    if (!RX) begin
                        cnt_s = 5'd0;
                    end else if (cnt_r == IDLE_LAST) begin
                        cnt_s   = 5'd0;
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
                ST_IDLE: begin
                    sof_s = ~RX;
                end
                ST_IDA: begin
                    id_s = {id_r[27:0], RX};
                    if (cnt_r == 5'd10) begin
                        cnt_s   = 5'd0;
                        state_s = ST_SRR;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
                ST_SRR: begin
                    rtr_s   = RX;
                    state_s = ST_IDE;
                end
                ST_IDE: begin
                    ide_s   = RX;
                    cnt_s   = 5'd0;
                    state_s = RX ? ST_IDB : ST_R0;
                end
                ST_IDB: begin
                    id_s = {id_r[27:0], RX};
                    if (cnt_r == 5'd17) begin
                        cnt_s   = 5'd0;
                        state_s = ST_RTR;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
                ST_RTR: begin
                    rtr_s   = RX;
                    state_s = ST_R1;
                end
                ST_R1: begin
                    state_s = ST_R0;
                end
                ST_R0: begin
                    cnt_s   = 5'd0;
                    state_s = ST_DLC;
                end
                ST_DLC: begin
                    dlc_s = {dlc_r[2:0], RX};
                    if (cnt_r == 5'd3) begin
                        cnt_s = 5'd0;
                        if (rtr_r) begin
                            data_left_s = 7'd0;
                        end else if (dlc_s[3]) begin
                            data_left_s = 7'd64;
                        end else begin
                            data_left_s = {1'b0, dlc_s[2:0], 3'b000};
                        end
                        state_s = (data_left_s == 7'd0) ? ST_CRC : ST_DATA;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
                ST_DATA: begin
                    data_s      = {data_r[62:0], RX};
                    data_left_s = data_left_r - 7'd1;
                    if (data_left_r == 7'd1) begin
                        cnt_s   = 5'd0;
                        state_s = ST_CRC;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_CRC: begin
                    crc_s = {crc_r[13:0], RX};
                    if (cnt_r == 5'd14) begin
                        cnt_s   = 5'd0;
                        state_s = ST_CRC_DEL;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
                ST_CRC_DEL: begin
                    if (RX) begin
                        state_s = ST_ACK_SLOT;
                    end else begin
                        form_err_s = 1'b0;
                        cnt_s      = 5'd0;
                        state_s    = ST_ERR_WAIT;
                    end
                end
                ST_ACK_SLOT: begin
                    state_s = ST_ACK_DEL;
                end
                ST_ACK_DEL: begin
                    cnt_s = 5'd0;
                    if (RX) begin
                        eof_flag_s = 1'b0;
                        state_s    = ST_EOF;
                    end else begin
                        form_err_s = 1'b0;
                        state_s    = ST_ERR_WAIT;
                    end
                end
                ST_EOF: begin
                    if (!RX) begin
                        form_err_s = 1'b0;
                    end else begin
                        form_err_s = form_err_r;
                    end
                    if (cnt_r == EOF_LAST) begin
                        eof_flag_s = 1'b1;
                        cnt_s      = 5'd0;
                        state_s    = ST_IFS;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
                ST_IFS: begin
                    if (!RX) begin
                        sof_s = 1'b1;
                    end else if (cnt_r == IFS_LAST) begin
                        frame_done_s = form_err_r;
                        cnt_s        = 5'd0;
                        state_s      = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
                default: begin
                    cnt_s   = 5'd0;
                    state_s = ST_INTEGRATE;
                end
            endcase
        end else begin
            frame_done_s = 1'b0;
        end

        // An accepted SOF counts as the first bit of a dominant run
        if (sof_s) begin
            id_s        = 29'd0;
            data_s      = 64'd0;
            crc_s       = 15'd0;
            stuff_err_s = 1'b1;
            form_err_s  = 1'b1;
            run_s       = 3'd1;
            last_s      = 1'b0;
            cnt_s       = 5'd0;
            state_s     = ST_IDA;
        end else begin
            last_s = last_s;
        end
    end

    // State and output registers
    always_ff @(posedge SP or posedge reset) begin
        if (reset) begin
            state_r      <= ST_INTEGRATE;
            cnt_r        <= 5'd0;
            run_r        <= 3'd0;
            last_r       <= 1'b0;
            data_left_r  <= 7'd0;
            id_r         <= 29'd0;
            ide_r        <= 1'b0;
            rtr_r        <= 1'b0;
            dlc_r        <= 4'd0;
            data_r       <= 64'd0;
            crc_r        <= 15'd0;
            eof_flag_r   <= 1'b1;
            frame_done_r <= 1'b0;
            stuff_err_r  <= 1'b1;
            form_err_r   <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            run_r        <= run_s;
            last_r       <= last_s;
            data_left_r  <= data_left_s;
            id_r         <= id_s;
            ide_r        <= ide_s;
            rtr_r        <= rtr_s;
            dlc_r        <= dlc_s;
            data_r       <= data_s;
            crc_r        <= crc_s;
            eof_flag_r   <= eof_flag_s;
            frame_done_r <= frame_done_s;
            stuff_err_r  <= stuff_err_s;
            form_err_r   <= form_err_s;
        end
    end
endmodule

// File: tb/tb_can_frame_tracker.sv
// Bench for can_frame_tracker: frames are built from their fields, bit-stuffed as a transmitter
// would do it, driven on RX, and the decoded outputs are compared with the original fields.
module tb_can_frame_tracker;
    logic        SP;
    logic        reset;
    logic        RX;
    logic        EOF_Flag;
    logic [28:0] ID;
    logic        IDE;
    logic        RTR;
    logic [3:0]  DLC;
    logic [63:0] Data;
    logic [14:0] CRC_Rx;
    logic        Frame_Done;
    logic        Stuff_Error;
    logic        Form_Error;

    int checks = 0;
    int errors = 0;
    int eof_low_n, done_n, stuff_low_n, form_low_n;
    bit raw_q[$];
    bit tx_q[$];

    can_frame_tracker #(.IDLE_BITS(11), .EOF_BITS(7), .IFS_BITS(3)) dut (
        .SP(SP), .reset(reset), .RX(RX), .EOF_Flag(EOF_Flag), .ID(ID), .IDE(IDE), .RTR(RTR),
        .DLC(DLC), .Data(Data), .CRC_Rx(CRC_Rx), .Frame_Done(Frame_Done),
        .Stuff_Error(Stuff_Error), .Form_Error(Form_Error)
    );

    initial SP = 1'b0;
    always #5 SP = ~SP;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        eof_low_n = 0; done_n = 0; stuff_low_n = 0; form_low_n = 0;
    endtask

    task automatic send_bit(input bit b);
        RX = b;
        @(posedge SP);
        #1;
        if (EOF_Flag === 1'b0) eof_low_n++;
        if (Frame_Done === 1'b1) done_n++;
        if (Stuff_Error === 1'b0) stuff_low_n++;
        if (Form_Error === 1'b0) form_low_n++;
    endtask

    task automatic send_tx();
        foreach (tx_q[i]) send_bit(tx_q[i]);
    endtask

    function automatic int data_bits(input bit rtr, input logic [3:0] dlc);
        if (rtr) return 0;
        return (dlc > 4'd8) ? 64 : 8 * int'(dlc);
    endfunction

    // Unstuffed SOF..CRC field sequence, then transmitter-side stuffing into tx_q
    task automatic build_frame(input bit ide, input logic [28:0] id, input bit rtr,
                               input logic [3:0] dlc, input logic [63:0] data,
                               input logic [14:0] crc);
        bit last;
        int run;
        int n;
        raw_q = {};
        raw_q.push_back(1'b0);
        if (!ide) begin
            for (int i = 10; i >= 0; i--) raw_q.push_back(id[i]);
            raw_q.push_back(rtr);
            raw_q.push_back(1'b0);
            raw_q.push_back(1'b0);
        end else begin
            for (int i = 28; i >= 18; i--) raw_q.push_back(id[i]);
            raw_q.push_back(1'b1);
            raw_q.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw_q.push_back(id[i]);
            raw_q.push_back(rtr);
            raw_q.push_back(1'b0);
            raw_q.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
        n = data_bits(rtr, dlc);
        for (int i = n - 1; i >= 0; i--) raw_q.push_back(data[i]);
        for (int i = 14; i >= 0; i--) raw_q.push_back(crc[i]);
        tx_q = {};
        last = 1'b1;
        run = 0;
        foreach (raw_q[i]) begin
            tx_q.push_back(raw_q[i]);
            if (raw_q[i] == last) run++;
            else begin run = 1; last = raw_q[i]; end
            if (run == 5) begin
                tx_q.push_back(~last);
                last = ~last;
                run = 1;
            end
        end
    endtask

    task automatic append_tail(input bit crc_del, input bit ack_del, input bit eof3);
        tx_q.push_back(crc_del);
        tx_q.push_back(1'b0);
        tx_q.push_back(ack_del);
        for (int i = 0; i < 7; i++) tx_q.push_back((i == 2) ? eof3 : 1'b1);
        for (int i = 0; i < 3; i++) tx_q.push_back(1'b1);
    endtask

    task automatic check_reset_values(input string p);
        check({p, "_eof_flag"}, 64'(EOF_Flag), 64'd1);
        check({p, "_stuff_err"}, 64'(Stuff_Error), 64'd1);
        check({p, "_form_err"}, 64'(Form_Error), 64'd1);
        check({p, "_done"}, 64'(Frame_Done), 64'd0);
        check({p, "_id"}, 64'(ID), 64'd0);
        check({p, "_ide"}, 64'(IDE), 64'd0);
        check({p, "_rtr"}, 64'(RTR), 64'd0);
        check({p, "_dlc"}, 64'(DLC), 64'd0);
        check({p, "_data"}, Data, 64'd0);
        check({p, "_crc"}, 64'(CRC_Rx), 64'd0);
    endtask

    task automatic run_frame(input string p, input bit ide, input logic [28:0] id, input bit rtr,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input logic [14:0] crc, input bit eof3);
        int n;
        logic [63:0] exp_data;
        logic [28:0] exp_id;
        build_frame(ide, id, rtr, dlc, data, crc);
        append_tail(1'b1, 1'b1, eof3);
        clear_stats();
        send_tx();
        n = data_bits(rtr, dlc);
        exp_data = (n == 64) ? data : (data & ((64'd1 << n) - 64'd1));
        exp_id = ide ? id : {18'd0, id[10:0]};
        check({p, "_id"}, 64'(ID), 64'(exp_id));
        check({p, "_ide"}, 64'(IDE), 64'(ide));
        check({p, "_rtr"}, 64'(RTR), 64'(rtr));
        check({p, "_dlc"}, 64'(DLC), 64'(dlc));
        check({p, "_data"}, Data, exp_data);
        check({p, "_crc"}, 64'(CRC_Rx), 64'(crc));
        check({p, "_eof_low_sps"}, 64'(eof_low_n), 64'd7);
        check({p, "_stuff_low_sps"}, 64'(stuff_low_n), 64'd0);
        check({p, "_eof_flag_end"}, 64'(EOF_Flag), 64'd1);
        if (eof3) begin
            check({p, "_form_low_sps"}, 64'(form_low_n), 64'd0);
            check({p, "_done_pulses"}, 64'(done_n), 64'd1);
        end else begin
            check({p, "_form_err"}, 64'(Form_Error), 64'd0);
        end
    endtask

    initial begin
        logic [28:0] rid;
        logic [63:0] rdata;
        logic [3:0]  rdlc;
        bit          ride;
        bit          rrtr;

        reset = 1'b1;
        RX = 1'b1;
        #12;
        check_reset_values("por");
        reset = 1'b0;
        repeat (11) send_bit(1'b1);

        run_frame("std123", 1'b0, 29'h123, 1'b0, 4'd2, 64'hA50F, 15'h1234, 1'b1);
        run_frame("ext_ones", 1'b1, 29'h1FFFFFFF, 1'b0, 4'd0, 64'h0, 15'h2AB3, 1'b1);
        run_frame("dlc15", 1'b0, 29'h7F0, 1'b0, 4'd15, 64'hDEADBEEF01234567, 15'h5A5A, 1'b1);
        run_frame("rtr_dlc4", 1'b1, 29'h0ABCDEF1, 1'b1, 4'd4, 64'hFFFFFFFFFFFFFFFF, 15'h0F0F, 1'b1);
        run_frame("eof3_dom", 1'b0, 29'h055, 1'b0, 4'd1, 64'h3C, 15'h1111, 1'b0);

        // Dominant CRC delimiter, then recovery needs a full recessive idle run
        build_frame(1'b0, 29'h2F0, 1'b0, 4'd1, 64'h81, 15'h7F00);
        clear_stats();
        send_tx();
        send_bit(1'b0);
        check("crcdel_form_err", 64'(Form_Error), 64'd0);
        send_bit(1'b0);
        repeat (11) send_bit(1'b1);
        check("crcdel_eof_low_sps", 64'(eof_low_n), 64'd0);
        check("crcdel_done_pulses", 64'(done_n), 64'd0);
        run_frame("after_crcdel", 1'b0, 29'h3A1, 1'b0, 4'd3, 64'h123456, 15'h0042, 1'b1);

        // Six dominant bits from SOF with no stuff bit
        clear_stats();
        repeat (6) send_bit(1'b0);
        check("stuff_err_flag", 64'(Stuff_Error), 64'd0);
        repeat (4) send_bit(1'b0);
        repeat (10) send_bit(1'b1);
        send_bit(1'b0);
        check("stuff_no_sof_after_10", 64'(Stuff_Error), 64'd0);
        repeat (11) send_bit(1'b1);
        check("stuff_eof_low_sps", 64'(eof_low_n), 64'd0);
        run_frame("after_stuff", 1'b0, 29'h6B2, 1'b0, 4'd8, 64'h0011223344556677, 15'h6001, 1'b1);

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 3)) send_bit(1'b1);
            ride = 1'($urandom_range(0, 1));
            rrtr = 1'($urandom_range(0, 1));
            rdlc = 4'($urandom_range(0, 15));
            rid = 29'($urandom);
            rdata = {$urandom, $urandom};
            run_frame($sformatf("rand%0d", k), ride, rid, rrtr, rdlc, rdata, 15'($urandom), 1'b1);
        end

        // Reset in the middle of the data field
        build_frame(1'b0, 29'h3C5, 1'b0, 4'd8, {$urandom, $urandom} | 64'h8000000000000000, 15'h1357);
        for (int i = 0; i < 35; i++) send_bit(tx_q[i]);
        #3 reset = 1'b1;
        #1 check_reset_values("mid");
        #1 reset = 1'b0;
        RX = 1'b1;
        repeat (5) send_bit(1'b1);
        build_frame(1'b0, 29'h2AA, 1'b0, 4'd1, 64'hC3, 15'h0F1E);
        append_tail(1'b1, 1'b1, 1'b1);
        clear_stats();
        send_tx();
        check("unintegrated_id", 64'(ID), 64'd0);
        check("unintegrated_eof_low_sps", 64'(eof_low_n), 64'd0);
        check("unintegrated_done", 64'(done_n), 64'd0);
        run_frame("after_reset", 1'b0, 29'h2AA, 1'b0, 4'd1, 64'hC3, 15'h0F1E, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/can_frame_tracker.md
Name: can_frame_tracker

Overview:
- Receive-side frame sequencer for the CAN decoder. It is clocked on the sample point SP and consumes the sampled bus bit RX.
- Performs bus integration, SOF detection, bit destuffing and field sequencing for standard and extended frames.
- Produces the active-low EOF_Flag consumed by the downstream EOF checker, plus decoded header/data fields and stuff/form error flags.
- Sits directly upstream of the EOF error stage; both share SP, RX and reset.

Parameters:
IDLE_BITS, 11, consecutive recessive bits required for bus integration and error recovery
EOF_BITS, 7, length of the EOF window during which EOF_Flag is low
IFS_BITS, 3, intermission length after EOF before SOF is accepted

Ports:
SP  input  1  clock; one rising edge per bit sample point
reset  input  1  asynchronous, active-high reset
RX  input  1  sampled bus bit; 0 = dominant, 1 = recessive
EOF_Flag  output  1  active-low; 0 while EOF bits are being sampled
ID  output  29  identifier; standard ID in [10:0] with upper bits 0, extended ID is {IDA,IDB}
IDE  output  1  1 = extended frame
RTR  output  1  remote request bit
DLC  output  4  data length code as received
Data  output  64  data bytes, shifted in MSB-first: Data <= {Data[62:0], bit}
CRC_Rx  output  15  received CRC sequence
Frame_Done  output  1  one-SP pulse when the last intermission bit is sampled without error
Stuff_Error  output  1  active-low; 0 = six equal bits seen in the stuffed region
Form_Error  output  1  active-low; 0 = dominant CRC delimiter, ACK delimiter or EOF bit

Behaviour:
- Interface: single clock SP; reset is asynchronous and active-high. All state updates on posedge SP.
- Reset values: EOF_Flag=1, Stuff_Error=1, Form_Error=1, Frame_Done=0. ID, IDE, RTR, DLC, Data and CRC_Rx are all 0. State is INTEGRATE with counters 0.
- Reset asserted mid-frame aborts immediately to these values.
- States:
  - INTEGRATE: count consecutive RX=1 (RX=0 clears the count). At IDLE_BITS go to IDLE.
  - IDLE: RX=0 is SOF. Clear ID, Data, CRC_Rx and both error flags to 1. Load stuff run = 1 with last bit = 0. Go to ARB.
  - ARB: IDA (11 bits), then SRR/RTR, then IDE.
    - IDE=0: store RTR, sample r0, go to DLC.
    - IDE=1: take IDB (18 bits), then RTR, r1, r0, go to DLC.
  - DLC: 4 bits. Data bit count = 0 if RTR=1, else 8*min(DLC,8). If the count is 0, go to CRC; otherwise go to DATA.
  - DATA, then CRC (15 bits).
  - CRC_DEL: RX must be 1, else Form_Error.
  - ACK_SLOT: either value is accepted.
  - ACK_DEL: RX must be 1, else Form_Error. EOF_Flag is registered 0 on this edge.
  - EOF: EOF_BITS bits. Any RX=0 raises Form_Error but the sequence continues. EOF_Flag returns to 1 on the edge sampling the last EOF bit.
  - IFS: IFS_BITS bits. A dominant bit aborts Frame_Done and goes to IDLE treated as SOF (overload is not decoded). Otherwise pulse Frame_Done on the last bit and go to IDLE.
- Destuffing is active from SOF through the 15th CRC bit inclusive, so a stuff bit may follow the last CRC bit.
  - After 5 equal bits, the next bit is a stuff bit. It is not delivered to the field logic.
  - If the stuff bit differs from the run, it starts a new run of length 1.
  - If it equals the run, drive Stuff_Error=0 and go to ERR_WAIT.
- ERR_WAIT: drive EOF_Flag=1. Wait IDLE_BITS consecutive recessive bits, then go to IDLE.
- Form_Error in CRC_DEL or ACK_DEL also goes to ERR_WAIT.
- Error flags stay low until the next accepted SOF or reset.
- The run counter is 3 bits and saturates; it must not wrap.
- The data counter is 7 bits (0..64).

Test Plan:
- Reset, then 11 recessive bits, then a standard frame with ID=0x123, RTR=0, DLC=2, data 0xA5,0x0F and correct stuffing → ID=0x123, IDE=0, DLC=2, Data[15:0]=0xA50F, EOF_Flag low for exactly 7 SPs, Frame_Done pulses once, both error flags stay 1.
- Extended frame with ID=0x1FFFFFFF (long recessive runs, stuff bits inserted) and DLC=0 → IDE=1, ID=0x1FFFFFFF, Data=0, no errors.
- ID=0x000 with the 6th dominant bit not stuffed → Stuff_Error=0 on that SP, EOF_Flag never goes low, SOF is accepted only after 11 recessive bits.
- DLC=15, RTR=0 → exactly 64 data bits are consumed and DLC output = 15. With RTR=1 and DLC=4, no data bits are consumed and the CRC follows the DLC directly.
- Dominant CRC delimiter → Form_Error=0 and ERR_WAIT entered. Separately, a dominant 3rd EOF bit → Form_Error=0 while EOF_Flag stays low through all 7 bits.
- Reset asserted during the DATA field → all outputs return to reset values asynchronously; no SOF is accepted until 11 recessive bits are seen.
